// File: rtl/div_sched.sv
// div_sched: 32-iteration restoring divide scheduler for the MIPS32 HI/LO path.
// Optional macro DIV_SIGNED_EN enables signed DIV; without it every request is DIVU.
module div_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  input  logic        stall_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [31:0] shifted, rem_n, quo_n;
  logic [31:0] fin_rem, fin_quo;
  logic        ge;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic neg1, neg2;

  always_comb begin
    neg1 = signed_div_i & opdata1_i[31];
    neg2 = signed_div_i & opdata2_i[31];
    mag1 = neg1 ? (32'd0 - opdata1_i) : opdata1_i;
    mag2 = neg2 ? (32'd0 - opdata2_i) : opdata2_i;
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;

  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
  end
`endif

  // One restoring step: subtract when the shifted partial remainder covers the divisor.
  always_comb begin
    shifted = {rem_q[30:0], quo_q[31]};
    ge      = ({rem_q, quo_q[31]} >= {1'b0, dvs_q});
    rem_n   = ge ? (shifted - dvs_q) : shifted;
    quo_n   = {quo_q[30:0], ge};
`ifdef DIV_SIGNED_EN
    fin_rem = neg_rem_q ? (32'd0 - rem_n) : rem_n;
    fin_quo = neg_quo_q ? (32'd0 - quo_n) : quo_n;
`else
    fin_rem = rem_n;
    fin_quo = quo_n;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          dvs_d = mag2;
`ifdef DIV_SIGNED_EN
          neg_quo_d = neg1 ^ neg2;
          neg_rem_d = neg1;
`endif
          if (opdata2_i == 32'd0) begin
            state_d = DIVZERO;
          end else begin
            state_d = BUSY;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quo_d   = mag1;
          end
        end
      end
      DIVZERO: begin
        result_d = 64'd0;
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      BUSY: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = {fin_rem, fin_quo};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!stall_i) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons everything in flight and keeps the last presented result.
    if (annul_i) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = ~rst & (((state_q == IDLE) & start_i & ~annul_i) |
                              (state_q == DIVZERO) | (state_q == BUSY));

endmodule
